// File: rtl/mem_access_stage.sv
// MEM stage: drives data-memory loads/stores over a req/ack handshake,
// stalls the pipeline while an access is in flight, and fills MEM/WB.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CW = $clog2(TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ALUresult,
    input  logic [4:0]  Wreg_addr,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemtoReg,
    input  logic        JtoPC,
    input  logic        Branch,
    input  logic        zero,
    input  logic [31:0] Branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] DM_Write_data,
    input  logic [31:0] next_PC,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_addr,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic        wb_MemtoReg,
    output logic [4:0]  wb_Wreg_addr,
    output logic [31:0] wb_ALUresult,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_next_PC,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          acc;
    logic          mis;
    logic          take;

    assign acc  = MemRead | MemWrite;
    assign mis  = acc & (ALUresult[1:0] != 2'b00);
    assign take = JtoPC | (Branch & zero);

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc && !mis) begin
                    stall    = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dm_ack || cnt == LAST)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (RST)
            stall = 1'b0;
    end

    always_comb begin
        redirect      = !RST && !stall && take;
        redirect_addr = 32'h0;
        if (redirect)
            redirect_addr = JtoPC ? jump_addr : Branch_addr;
    end

    // Pipeline registers update on the falling edge.
    always_ff @(negedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            rdata_q      <= 32'h0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= 32'h0;
            dm_wdata     <= 32'h0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
            wb_Wreg_addr <= 5'h0;
            wb_ALUresult <= 32'h0;
            wb_read_data <= 32'h0;
            wb_next_PC   <= 32'h0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (acc && !mis) begin
                        dm_req   <= 1'b1;
                        dm_we    <= MemWrite;
                        dm_addr  <= ALUresult;
                        dm_wdata <= DM_Write_data;
                        cnt      <= '0;
                    end
                    if (mis)
                        err_misalign <= 1'b1;
                end
                WAIT: begin
                    if (dm_ack) begin
                        rdata_q <= dm_rdata;
                        dm_req  <= 1'b0;
                    end else if (cnt == LAST) begin
                        rdata_q     <= 32'h0;
                        dm_req      <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // Stalled or misaligned: push a bubble, keep the payload.
            if (stall || (state == IDLE && mis)) begin
                wb_valid    <= 1'b0;
                wb_RegWrite <= 1'b0;
            end else begin
                wb_valid     <= 1'b1;
                wb_RegWrite  <= RegWrite;
                wb_MemtoReg  <= MemtoReg;
                wb_Wreg_addr <= Wreg_addr;
                wb_ALUresult <= ALUresult;
                wb_next_PC   <= next_PC;
            end
            wb_read_data <= (state == DONE) ? rdata_q : 32'h0;
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register: the MEM stage of the 5-stage MIPS pipeline.
- Takes the EX/MEM register outputs and runs data-memory loads and stores over a req/ack handshake.
- Stalls the pipeline while an access is outstanding, resolves branch/jump redirects, and drives the MEM/WB register fields.

Parameters:
- TIMEOUT, 16, max WAIT cycles without dm_ack before the access is aborted (≥1).
- CW, $clog2(TIMEOUT+1), wait-counter width (derived).

Ports:
- CLK  in  1  clock; all state updates on negedge CLK, the same edge as the pipeline registers.
- RST  in  1  synchronous, active-high reset, sampled on that edge.
- ALUresult  in  32  memory address / ALU result.
- Wreg_addr  in  5  destination register.
- RegWrite, MemWrite, MemRead, MemtoReg, JtoPC, Branch, zero  in  1 each  EX/MEM control.
- Branch_addr, jump_addr, DM_Write_data, next_PC  in  32 each  EX/MEM data.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  1 = store, registered.
- dm_addr  out  32  word address, registered.
- dm_wdata  out  32  store data, registered.
- dm_ack  in  1  one-cycle completion pulse.
- dm_rdata  in  32  load data, valid with dm_ack.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- redirect  out  1  combinational; PC takes redirect_addr.
- redirect_addr  out  32  combinational.
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB fields.
- wb_Wreg_addr  out  5  MEM/WB field.
- wb_ALUresult, wb_read_data, wb_next_PC  out  32 each  MEM/WB fields.
- err_misalign, err_timeout  out  1 each  sticky error flags.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0. Reset applies on the next edge even mid-WAIT: dm_req drops and the transaction is abandoned. A late dm_ack after reset is ignored.
- acc = MemRead | MemWrite. MemWrite wins if both are set, so dm_we = MemWrite.
- mis = acc & (ALUresult[1:0] != 0).
- FSM states: IDLE, WAIT, DONE.
  - IDLE, acc & !mis: stall=1. On the edge: dm_req<=1, dm_we, dm_addr<=ALUresult, dm_wdata<=DM_Write_data, cnt<=0, go WAIT.
  - IDLE, mis: no request, stall=0, err_misalign<=1. MEM/WB gets a bubble (wb_valid=0, wb_RegWrite=0).
  - IDLE, otherwise: stall=0, pass-through.
  - WAIT: stall=1, dm_req held with address and data stable.
    - dm_ack=1: rdata_q<=dm_rdata, dm_req<=0, go DONE.
    - Else if cnt==TIMEOUT-1: dm_req<=0, err_timeout<=1, rdata_q<=0, go DONE.
    - Else cnt<=cnt+1.
  - DONE: stall=0, go IDLE. EX/MEM advances on this same edge.
- dm_ack outside WAIT is ignored.
- MEM/WB update, every edge:
  - stall=1: wb_valid<=0, wb_RegWrite<=0; other wb fields hold.
  - stall=0, normal: wb_valid<=1, wb_RegWrite<=RegWrite, wb_MemtoReg, wb_Wreg_addr, wb_ALUresult<=ALUresult, wb_next_PC<=next_PC.
  - wb_read_data <= rdata_q in DONE, else 0.
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Memory access: 1 (IDLE) + N (WAIT, N = cycles until ack, ≥1) + 1 (DONE). An ack on the first WAIT cycle gives 3 cycles total.
- Redirect (combinational):
  - redirect = !RST & !stall & (JtoPC | (Branch & zero)).
  - redirect_addr = JtoPC ? jump_addr : Branch_addr; JtoPC has priority.
  - redirect_addr is 0 when redirect is 0.
- Sticky flags clear only on RST.

Test Plan:
- ALU op RegWrite=1, Wreg_addr=5, ALUresult=0x1234: next edge wb_valid=1, wb_RegWrite=1, wb_ALUresult=0x1234, stall never high.
- Load MemRead=1, ALUresult=0x40, ack 3 cycles after dm_req, dm_rdata=0xCAFEF00D: dm_addr=0x40, dm_we=0, stall high for 4 cycles, then wb_read_data=0xCAFEF00D, wb_MemtoReg=1. Bubbles (wb_RegWrite=0) appear during the stall.
- Store MemWrite=1, ALUresult=0x80, DM_Write_data=0x55AA: dm_we=1, dm_wdata=0x55AA held until ack. MemRead=MemWrite=1 also issues a store.
- Misaligned load ALUresult=0x42: dm_req stays 0, err_misalign=1, wb_RegWrite=0, no stall.
- TIMEOUT=4, no ack: dm_req drops after 4 WAIT cycles, err_timeout=1, wb_read_data=0. RST during WAIT gives dm_req=0, IDLE, flags cleared, and a subsequent ack is ignored.
- Branch=1, zero=1, Branch_addr=0x100 gives redirect=1, addr 0x100. Adding JtoPC=1 with jump_addr=0x200 gives addr 0x200. Branch=1, zero=0 gives redirect=0.
